// File: rtl/mac_row_flex.sv
// Systolic MAC row with weight-stationary and output-stationary dataflows.
// Activations skew east one column per cycle; OS results leave on drain.
module mac_row_flex #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w,
  input  logic [1:0]             inst_w,
  input  logic                   mode,
  input  logic                   drain,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   busy
);

  logic [col-1:0][bw-1:0]      a_q, w_q, wn_q;
  logic [col-1:0][bw-1:0]      west_a, wt;
  logic [col-1:0][1:0]         inst_q, west_i;
  logic [col-1:0][psum_bw-1:0] c_q, dr_q, nb, pr;
  logic [col-1:0]              load_ready;
  logic                        mode_q, drain_q;

  // unsigned activation times signed weight, wrapped to psum_bw
  function automatic logic [psum_bw-1:0] mul(
    input logic [bw-1:0] a,
    input logic [bw-1:0] w
  );
    logic [psum_bw-1:0] ea, ew;
    ea = {{(psum_bw-bw){1'b0}}, a};
    ew = {{(psum_bw-bw){w[bw-1]}}, w};
    return ea * ew;
  endfunction

  always_comb begin
    west_a = {a_q[col-2:0], in_w};
    west_i = {inst_q[col-2:0], inst_w};
    nb = '0;
    wt = '0;
    pr = '0;
    for (int j = 0; j < col; j++) begin
      nb[j] = in_n[j*psum_bw +: psum_bw];
      wt[j] = in_n[j*psum_bw +: bw];
      pr[j] = mul(west_a[j], mode_q ? in_n[j*psum_bw +: bw] : w_q[j]);
    end
  end

  assign busy = (|inst_q) | drain_q;

  always_comb begin
    out_s = '0;
    valid = '0;
    for (int j = 0; j < col; j++) begin
      if (mode_q) begin
        out_s[j*psum_bw +: psum_bw] = drain_q ? dr_q[j]
          : {{(psum_bw-bw){1'b0}}, wn_q[j]};
        valid[j] = drain_q;
      end else begin
        out_s[j*psum_bw +: psum_bw] = c_q[j];
        valid[j] = inst_q[j][1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      w_q        <= '0;
      wn_q       <= '0;
      inst_q     <= '0;
      c_q        <= '0;
      dr_q       <= '0;
      load_ready <= '1;
      mode_q     <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      if (!busy && inst_w == 2'b00 && !drain)
        mode_q <= mode;
      drain_q <= drain & mode_q;
      for (int j = 0; j < col; j++) begin
        inst_q[j][1] <= west_i[j][1];
        if (west_i[j][1])
          a_q[j] <= west_a[j];
        if (!mode_q) begin
          inst_q[j][0] <= 1'b0;
          if (west_i[j][0]) begin
            if (load_ready[j]) begin
              w_q[j]        <= west_a[j];
              load_ready[j] <= 1'b0;
            end else begin
              a_q[j]       <= west_a[j];
              inst_q[j][0] <= 1'b1;
            end
          end
          if (west_i[j][1])
            c_q[j] <= nb[j] + pr[j];
        end else begin
          inst_q[j][0] <= 1'b0;
          if (west_i[j][1])
            wn_q[j] <= wt[j];
          // a coinciding execute starts the fresh accumulation
          if (drain) begin
            dr_q[j] <= c_q[j];
            c_q[j]  <= west_i[j][1] ? pr[j] : '0;
          end else if (west_i[j][1]) begin
            c_q[j] <= c_q[j] + pr[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_row_flex.sv
// Bench for mac_row_flex: directed steps with random data against an
// arithmetic reference of both dataflows.
module tb_mac_row_flex;

  localparam int BW = 4;
  localparam int PB = 16;
  localparam int NC = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [BW-1:0]    in_w;
  logic [1:0]       inst_w;
  logic             mode;
  logic             drain;
  logic [PB*NC-1:0] in_n;
  logic [PB*NC-1:0] out_s;
  logic [NC-1:0]    valid;
  logic             busy;

  mac_row_flex #(.bw(BW), .psum_bw(PB), .col(NC)) dut (
    .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w),
    .mode(mode), .drain(drain), .in_n(in_n), .out_s(out_s),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int wm [NC];
  int wt_m [NC];
  int ex_e [$];
  int ex_a [$];
  int last_d;

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_w   = 4'($urandom);
      inst_w = 2'($urandom);
      mode   = 1'($urandom);
      drain  = 1'($urandom);
      in_n   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    reset  = 1'b0;
    in_w   = '0;
    inst_w = 2'b00;
    mode   = 1'b0;
    drain  = 1'b0;
    in_n   = '0;
    for (int j = 0; j < NC; j++) wm[j] = 0;
    ex_e.delete();
    ex_a.delete();
    last_d = edge_n + 1;
  endtask

  task automatic ws_load(input int n);
    logic [BW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = 4'($urandom);
      if (i < NC) wm[i] = int'($signed(v));
      in_w   = v;
      inst_w = 2'b01;
      tick();
    end
    inst_w = 2'b00;
  endtask

  task automatic ws_load_fixed(input logic [BW-1:0] v0,
                               input logic [BW-1:0] v1);
    in_w = v0; inst_w = 2'b01; tick();
    in_w = v1; tick();
    wm[0] = int'($signed(v0));
    wm[1] = int'($signed(v1));
    inst_w = 2'b00;
  endtask

  task automatic ws_exec(input logic [BW-1:0] a,
                         input logic [PB*NC-1:0] nv);
    int v;
    logic [31:0] e;
    in_w = a; inst_w = 2'b10; in_n = nv;
    tick();
    for (int k = 0; k < NC; k++) begin
      if (k > 0) begin
        inst_w = 2'b00;
        in_w   = 4'($urandom);
        mode   = 1'($urandom);
        tick();
      end
      chk("ws_valid", 32'(valid), 32'(8'b1 << k));
      v = int'($signed(nv[k*PB +: PB])) + int'(a) * wm[k];
      e = {16'h0, v[15:0]};
      chk("ws_out", 32'(out_s[k*PB +: PB]), e);
    end
    inst_w = 2'b00;
    mode   = 1'($urandom);
    tick();
    mode = 1'b0;
    chk("ws_idle_valid", 32'(valid), 32'h0);
    chk("ws_idle_busy", 32'(busy), 32'h0);
  endtask

  task automatic os_enter(input logic [PB*NC-1:0] nv);
    do_reset(2);
    in_n = nv;
    for (int j = 0; j < NC; j++)
      wt_m[j] = int'($signed(nv[j*PB +: BW]));
    mode = 1'b1;
    tick();
  endtask

  task automatic os_exec(input logic [BW-1:0] a);
    in_w = a; inst_w = 2'b10;
    ex_e.push_back(edge_n + 1);
    ex_a.push_back(int'(a));
    tick();
    inst_w = 2'b00;
  endtask

  task automatic idle(input int n);
    inst_w = 2'b00;
    drain  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic os_drain(input bit with_ex, input logic [BW-1:0] a);
    int d, s;
    logic [31:0] e;
    d = edge_n + 1;
    drain = 1'b1;
    if (with_ex) begin
      in_w = a; inst_w = 2'b10;
      ex_e.push_back(d);
      ex_a.push_back(int'(a));
    end
    tick();
    drain  = 1'b0;
    inst_w = 2'b00;
    chk("os_drain_valid", 32'(valid), 32'hFF);
    chk("os_drain_busy", 32'(busy), 32'h1);
    for (int j = 0; j < NC; j++) begin
      s = 0;
      foreach (ex_e[i])
        if (ex_e[i] + j >= last_d && ex_e[i] + j < d)
          s += ex_a[i] * wt_m[j];
      e = {16'h0, s[15:0]};
      chk("os_drain_out", 32'(out_s[j*PB +: PB]), e);
    end
    last_d = d;
  endtask

  initial begin
    logic [PB*NC-1:0] nv;
    reset = 1'b1; in_w = '0; inst_w = '0; mode = 1'b0;
    drain = 1'b0; in_n = '0;

    // reset with random inputs
    do_reset(2);
    chk("rst_out", 32'(out_s == '0), 32'h1);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    nv = {$urandom, $urandom, $urandom, $urandom};
    in_n = nv; in_w = 4'($urandom); inst_w = 2'b10; mode = 1'b1;
    tick();
    chk("rst_mode_ws_valid", 32'(valid), 32'h01);
    chk("rst_mode_ws_out", 32'(out_s[PB-1:0]), 32'(nv[PB-1:0]));
    mode = 1'b0;
    idle(NC + 1);
    chk("rst_idle_busy", 32'(busy), 32'h0);

    // WS weights 1..8, execute a=3
    do_reset(2);
    for (int i = 0; i < NC; i++) begin
      in_w = 4'(i + 1); inst_w = 2'b01;
      wm[i] = int'($signed(4'(i + 1)));
      tick();
    end
    inst_w = 2'b00;
    ws_exec(4'd3, '0);

    // WS sign and wrap
    do_reset(2);
    ws_load_fixed(4'h8, 4'h1);
    ws_exec(4'd15, '0);
    nv = '0;
    for (int j = 0; j < NC; j++) nv[j*PB +: PB] = 16'h7FFF;
    ws_exec(4'd1, nv);

    // WS random
    do_reset(2);
    ws_load(NC);
    for (int r = 0; r < 4; r++)
      ws_exec(4'($urandom), {$urandom, $urandom, $urandom, $urandom});

    // reset in the middle of a load
    do_reset(2);
    ws_load(3);
    do_reset(1);
    ws_load(NC);
    ws_exec(4'($urandom), {$urandom, $urandom, $urandom, $urandom});

    // OS accumulate a=2 w=3 four times, then drain twice
    nv = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < NC; j++) nv[j*PB +: BW] = 4'd3;
    os_enter(nv);
    for (int i = 0; i < 4; i++) os_exec(4'd2);
    idle(8);
    os_drain(1'b0, '0);
    chk("os_24", 32'(out_s[PB-1:0]), 32'd24);
    idle(1);
    chk("os_post_valid", 32'(valid), 32'h0);
    chk("os_post_busy", 32'(busy), 32'h0);
    for (int j = 0; j < NC; j++)
      chk("os_wn", 32'(out_s[j*PB +: PB]), 32'd3);
    os_drain(1'b0, '0);

    // drain coinciding with execute at column 0
    nv = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < NC; j++) nv[j*PB +: BW] = 4'd2;
    os_enter(nv);
    os_exec(4'd5);
    idle(NC + 1);
    os_drain(1'b1, 4'd5);
    idle(NC + 1);
    os_drain(1'b0, '0);
    chk("os_coin_col0", 32'(out_s[PB-1:0]), 32'd10);

    // OS random traffic with drains landing mid-flight
    os_enter({$urandom, $urandom, $urandom, $urandom});
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0, 1: os_exec(4'($urandom));
        2: idle(1);
        default: begin
          os_drain(1'($urandom), 4'($urandom));
        end
      endcase
    end
    idle(NC + 1);
    os_drain(1'b0, '0);
    idle(1);
    chk("os_rand_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
